// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: operand, MTHI/MTLO and result bundle between pipeline and mul_div_unit
interface mul_div_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             hiWrite;
    logic             loWrite;
    logic [WIDTH-1:0] writeData;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master (output start, op, srcA, srcB, hiWrite, loWrite, writeData,
                    input busy, done, hi, lo);
    modport slave (input start, op, srcA, srcB, hiWrite, loWrite, writeData,
                   output busy, done, hi, lo);
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MIPS MULT/MULTU/DIV/DIVU on magnitudes with sign fix-up into HI/LO
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input logic           clk,
    input logic           rst_n,
    mul_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t             state, next;
    logic [CW-1:0]      cnt;
    logic               is_div, neg_res, neg_rem, busy, done;
    logic [WIDTH-1:0]   b, q, hi, lo;
    logic [WIDTH:0]     r;
    logic               sgn, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, quo_fix, rem_fix;
    logic [WIDTH:0]     mul_sum, shl;
    logic [WIDTH+1:0]   diff;
    logic [2*WIDTH-1:0] prod, prod_fix;
    always_comb begin
        sgn      = ~bus.op[0];
        a_neg    = sgn & bus.srcA[WIDTH-1];
        b_neg    = sgn & bus.srcB[WIDTH-1];
        a_mag    = a_neg ? -bus.srcA : bus.srcA;
        b_mag    = b_neg ? -bus.srcB : bus.srcB;
        mul_sum  = {1'b0, r[WIDTH-1:0]} + (q[0] ? {1'b0, b} : '0);
        shl      = {r[WIDTH-1:0], q[WIDTH-1]};
        diff     = {1'b0, shl} - {2'b0, b};
        prod     = {r[WIDTH-1:0], q};
        prod_fix = neg_res ? -prod : prod;
        quo_fix  = (b == '0) ? '1 : neg_res ? -q : q;
        rem_fix  = neg_rem ? -r[WIDTH-1:0] : r[WIDTH-1:0];
    end
    always_comb begin
        next = state;
        next = (state == IDLE) ? (bus.start ? CALC : IDLE) :
               (state == CALC) ? ((cnt == CW'(WIDTH - 1)) ? FIX : CALC) : IDLE;
    end
    // Both operations start from r=0, q=|A|; multiply shifts right, divide shifts left.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= next;
            busy  <= next != IDLE;
            done  <= state == FIX;
            if (state == IDLE) begin
                if (bus.start) begin
                    is_div  <= bus.op[1];
                    neg_res <= a_neg ^ b_neg;
                    neg_rem <= a_neg;
                    b       <= b_mag;
                    q       <= a_mag;
                    r       <= '0;
                    cnt     <= '0;
                end else begin
                    if (bus.hiWrite) hi <= bus.writeData;
                    if (bus.loWrite) lo <= bus.writeData;
                end
            end else if (state == CALC) begin
                cnt <= cnt + 1'b1;
                if (is_div) begin
                    r <= diff[WIDTH+1] ? shl : diff[WIDTH:0];
                    q <= {q[WIDTH-2:0], ~diff[WIDTH+1]};
                end else begin
                    r <= {1'b0, mul_sum[WIDTH:1]};
                    q <= {mul_sum[0], q[WIDTH-1:1]};
                end
            end else if (state == FIX) begin
                hi <= is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
                lo <= is_div ? quo_fix : prod_fix[WIDTH-1:0];
            end
        end
    end
    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.hi   = hi;
    assign bus.lo   = lo;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and randomized checks of mul_div_unit against a plain-arithmetic model
module tb_mul_div_unit;
    logic clk = 0;
    logic rst_n = 0;
    int   vectors = 0;
    int   errors = 0;
    mul_div_unit_if #(.WIDTH(32)) bus ();
    mul_div_unit #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, sq, sr;
        logic [63:0] ua, ub, uq, ur;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (o == 2'b00) return sa * sb;
        if (o == 2'b01) return ua * ub;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (o == 2'b10) begin
            sq = sa / sb;
            sr = sa % sb;
            return {sr[31:0], sq[31:0]};
        end
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output int bcnt);
        @(negedge clk);
        bus.start = 1; bus.op = o; bus.srcA = a; bus.srcB = b;
        @(negedge clk);
        bus.start = 0;
        cyc = 0;
        bcnt = 0;
        while (!bus.done && cyc < 100) begin
            bcnt += int'(bus.busy);
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        vectors++;
        if ({bus.hi, bus.lo, bus.busy, bus.done} !== 66'b0) begin
            errors++;
            $display("FAIL reset: hi=%h lo=%h busy=%b done=%b, want all zero", bus.hi, bus.lo, bus.busy, bus.done);
        end
    endtask

    task automatic test_multu_max();
        int cyc, bcnt;
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, bcnt);
        vectors++;
        if (cyc !== 33) begin errors++; $display("FAIL latency: got %0d edges, want 33", cyc); end
        vectors++;
        if (bcnt !== 33 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL busy_len: busy %0d cycles, busy_at_done=%b, want 33 and 0", bcnt, bus.busy);
        end
        vectors++;
        if ({bus.hi, bus.lo} !== 64'hFFFF_FFFE_0000_0001) begin
            errors++; $display("FAIL multu_max: got %h_%h, want fffffffe_00000001", bus.hi, bus.lo);
        end
        @(negedge clk);
        vectors++;
        if (bus.done !== 1'b0 || {bus.hi, bus.lo} !== 64'hFFFF_FFFE_0000_0001) begin
            errors++; $display("FAIL done_pulse: done=%b hi=%h lo=%h, want 0 and held result", bus.done, bus.hi, bus.lo);
        end
    endtask

    task automatic test_directed();
        logic [1:0]  ops [5] = '{2'b00, 2'b10, 2'b11, 2'b11, 2'b10};
        logic [31:0] as  [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'h1234_5678, 32'h8000_0000};
        logic [31:0] bs  [5] = '{32'd5, 32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF};
        logic [63:0] want [5] = '{64'hFFFF_FFFF_FFFF_FFF1, 64'hFFFF_FFFF_FFFF_FFFD,
                                  64'h0000_0002_0000_000E, 64'h1234_5678_FFFF_FFFF,
                                  64'h0000_0000_8000_0000};
        int cyc, bcnt;
        for (int i = 0; i < 5; i++) begin
            run_op(ops[i], as[i], bs[i], cyc, bcnt);
            vectors++;
            if (cyc !== 33 || {bus.hi, bus.lo} !== want[i]) begin
                errors++;
                $display("FAIL directed[%0d]: op=%0d a=%h b=%h got %h_%h after %0d, want %h after 33",
                         i, ops[i], as[i], bs[i], bus.hi, bus.lo, cyc, want[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] edge_v [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
        logic [1:0]  o;
        logic [31:0] a, b;
        logic [63:0] want;
        int cyc, bcnt;
        for (int i = 0; i < 60; i++) begin
            o = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(0, 31);
            want = model(o, a, b);
            run_op(o, a, b, cyc, bcnt);
            vectors++;
            if (cyc !== 33 || {bus.hi, bus.lo} !== want) begin
                errors++;
                $display("FAIL random[%0d]: op=%0d a=%h b=%h got %h_%h after %0d, want %h after 33",
                         i, o, a, b, bus.hi, bus.lo, cyc, want);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int cyc;
        @(negedge clk);
        bus.start = 1; bus.op = 2'b11; bus.srcA = 32'd100; bus.srcB = 32'd7;
        @(negedge clk);
        bus.start = 0;
        repeat (4) @(negedge clk);
        bus.start = 1; bus.op = 2'b01; bus.srcA = 32'd3; bus.srcB = 32'd3;
        bus.hiWrite = 1; bus.writeData = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.start = 0; bus.hiWrite = 0;
        cyc = 5;
        while (!bus.done && cyc < 100) begin @(negedge clk); cyc++; end
        vectors++;
        if (cyc !== 33 || bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
            errors++; $display("FAIL busy_ignore: hi=%h lo=%h after %0d, want 2/14 after 33", bus.hi, bus.lo, cyc);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL no_relaunch: busy=%b done=%b, want 0/0", bus.busy, bus.done);
        end
    endtask

    task automatic test_mt();
        int cyc;
        bus.hiWrite = 1; bus.writeData = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.hiWrite = 0;
        vectors++;
        if (bus.hi !== 32'hDEAD_BEEF || bus.lo !== 32'd14) begin
            errors++; $display("FAIL mthi: hi=%h lo=%h, want deadbeef/0000000e", bus.hi, bus.lo);
        end
        bus.loWrite = 1; bus.writeData = 32'hCAFE_F00D;
        @(negedge clk);
        bus.loWrite = 0;
        vectors++;
        if (bus.hi !== 32'hDEAD_BEEF || bus.lo !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL mtlo: hi=%h lo=%h, want deadbeef/cafef00d", bus.hi, bus.lo);
        end
        bus.hiWrite = 1; bus.loWrite = 1; bus.writeData = 32'h0BAD_0BAD;
        @(negedge clk);
        bus.hiWrite = 0; bus.loWrite = 0;
        vectors++;
        if (bus.hi !== 32'h0BAD_0BAD || bus.lo !== 32'h0BAD_0BAD) begin
            errors++; $display("FAIL mt_both: hi=%h lo=%h, want 0bad0bad/0bad0bad", bus.hi, bus.lo);
        end
        bus.start = 1; bus.op = 2'b11; bus.srcA = 32'd100; bus.srcB = 32'd7;
        bus.hiWrite = 1; bus.loWrite = 1; bus.writeData = 32'h1111_1111;
        @(negedge clk);
        bus.start = 0; bus.hiWrite = 0; bus.loWrite = 0;
        vectors++;
        if (bus.hi !== 32'h0BAD_0BAD || bus.busy !== 1'b1) begin
            errors++; $display("FAIL start_wins: hi=%h busy=%b, want 0bad0bad/1", bus.hi, bus.busy);
        end
        cyc = 0;
        while (!bus.done && cyc < 100) begin @(negedge clk); cyc++; end
        vectors++;
        if (bus.hi !== 32'd2 || bus.lo !== 32'd14) begin
            errors++; $display("FAIL start_wins_res: hi=%h lo=%h, want 2/14", bus.hi, bus.lo);
        end
    endtask

    task automatic test_reset_abort();
        int pulses, cyc, bcnt;
        @(negedge clk);
        bus.start = 1; bus.op = 2'b01; bus.srcA = 32'hFFFF_FFFF; bus.srcB = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.start = 0;
        repeat (9) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        vectors++;
        if ({bus.hi, bus.lo, bus.busy, bus.done} !== 66'b0) begin
            errors++; $display("FAIL abort: hi=%h lo=%h busy=%b done=%b, want all zero", bus.hi, bus.lo, bus.busy, bus.done);
        end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            pulses += int'(bus.done);
        end
        vectors++;
        if (pulses !== 0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            errors++; $display("FAIL abort_quiet: %0d done pulses hi=%h lo=%h, want 0/0/0", pulses, bus.hi, bus.lo);
        end
        run_op(2'b01, 32'd6, 32'd7, cyc, bcnt);
        vectors++;
        if (cyc !== 33 || bus.hi !== 32'd0 || bus.lo !== 32'd42) begin
            errors++; $display("FAIL after_abort: hi=%h lo=%h after %0d, want 0/42 after 33", bus.hi, bus.lo, cyc);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bcnt;
        logic [31:0] a, b;
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom;
            run_op(2'(i), a, b, cyc, bcnt);
            vectors++;
            if (cyc !== 33 || bcnt !== 33 || {bus.hi, bus.lo} !== model(2'(i), a, b)) begin
                errors++;
                $display("FAIL back_to_back[%0d]: a=%h b=%h got %h_%h cyc=%0d busy=%0d, want %h 33/33",
                         i, a, b, bus.hi, bus.lo, cyc, bcnt, model(2'(i), a, b));
            end
        end
    endtask

    initial begin
        bus.start = 0; bus.op = 0; bus.srcA = 0; bus.srcB = 0;
        bus.hiWrite = 0; bus.loWrite = 0; bus.writeData = 0;
        test_reset();
        test_multu_max();
        test_directed();
        test_random();
        test_busy_ignore();
        test_mt();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
